// File: rtl/mac_pkg.sv
// MAC array constants shared by the IFM/WFM feed paths.
package mac_pkg;

  localparam int unsigned MAC_W_ELEMENT = 8;
  localparam int unsigned MAC_LANES     = 64;

endpackage

// File: rtl/tx_pkg.sv
// Transfer types between the line buffers, the feeders and the MAC array.
package tx_pkg;

  import mac_pkg::*;

  localparam int unsigned TX_CNT_W = 16;

  typedef struct packed {
    logic [MAC_LANES-1:0][MAC_W_ELEMENT-1:0] data;
    logic [MAC_LANES-1:0]                    element_valid;
    logic                                    inter_end;
    logic                                    accum_end;
  } mac_ifm_port;

  typedef struct packed {
    logic [6:0]          lane_cnt;
    logic [TX_CNT_W-1:0] inter_len;
    logic [TX_CNT_W-1:0] accum_len;
    logic [TX_CNT_W-1:0] job_len;
  } mac_ifm_feeder_cfg;

  // Zero in any field means "the natural default": 64 lanes, or a loop length of 1.
  function automatic mac_ifm_feeder_cfg cfg_sanitize(input logic [6:0]          lane_cnt,
                                                     input logic [TX_CNT_W-1:0] inter_len,
                                                     input logic [TX_CNT_W-1:0] accum_len,
                                                     input logic [TX_CNT_W-1:0] job_len);
    mac_ifm_feeder_cfg c;
    c.lane_cnt  = (lane_cnt == 7'd0) ? 7'(MAC_LANES) : lane_cnt;
    c.inter_len = (inter_len == '0) ? TX_CNT_W'(1) : inter_len;
    c.accum_len = (accum_len == '0) ? TX_CNT_W'(1) : accum_len;
    c.job_len   = (job_len == '0) ? TX_CNT_W'(1) : job_len;
    return c;
  endfunction

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry skid buffer, generic over the payload type. Ready upstream is derived from
// o_entries only, so no combinational path runs from i_ready back to the producer.
module tx_skid_buf #(
  parameter type T = logic
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  T           i_data,
  output logic       o_valid,
  output T           o_data,
  input  logic       i_ready,
  output logic [1:0] o_entries
);

  logic [1:0] cnt_q, cnt_d;
  logic       wr_q, rd_q;
  logic       push_ok, pop;
  T           mem_q [2];

  assign push_ok   = i_push && (cnt_q != 2'd2);
  assign pop       = o_valid && i_ready;
  assign o_valid   = (cnt_q != 2'd0);
  assign o_data    = mem_q[rd_q];
  assign o_entries = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) begin
        mem_q[wr_q] <= i_data;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
    end
  end

endmodule

// File: rtl/mac_ifm_feeder.sv
// Feeds lane-masked, loop-tagged IFM beats to the MAC array through a 2-entry skid buffer.
// Define MAC_IFM_FEEDER_STAT_EN to add the o_stall_cnt output-backpressure counter.
module mac_ifm_feeder
  import mac_pkg::*;
  import tx_pkg::*;
#(
  parameter int unsigned CNT_W  = TX_CNT_W,
  parameter int unsigned ELEM_W = MAC_W_ELEMENT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [6:0]                  i_cfg_lane_cnt,
  input  logic [CNT_W-1:0]            i_cfg_inter_len,
  input  logic [CNT_W-1:0]            i_cfg_accum_len,
  input  logic [CNT_W-1:0]            i_cfg_job_len,
  input  logic [ELEM_W*MAC_LANES-1:0] i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output mac_ifm_port                 o_ifm,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_busy,
  output logic                        o_done
`ifdef MAC_IFM_FEEDER_STAT_EN
  ,
  output logic [31:0]                 o_stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e            state_q, state_d;
  mac_ifm_feeder_cfg cfg_q, cfg_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  inter_q, inter_d;
  logic [CNT_W-1:0]  accum_q, accum_d;
  logic              done_q, done_d;
  logic [1:0]        entries;
  logic              in_acc, push;
  logic              inter_end, accum_end, job_last;
  logic [MAC_LANES-1:0] lane_en;
  mac_ifm_port       beat;

  assign o_ready   = (state_q == StRun) && (entries != 2'd2);
  assign in_acc    = i_valid && o_ready;
  assign o_busy    = (state_q != StIdle);
  assign o_done    = done_q;
  assign inter_end = (beat_q == cfg_q.inter_len - CntOne);
  assign accum_end = inter_end && (inter_q == cfg_q.accum_len - CntOne);
  assign job_last  = accum_end && (accum_q == cfg_q.job_len - CntOne);

  always_comb begin
    beat    = '0;
    lane_en = '0;
    for (int unsigned i = 0; i < MAC_LANES; i++) begin
      lane_en[i]   = (7'(i) < cfg_q.lane_cnt);
      beat.data[i] = lane_en[i] ? i_data[i*ELEM_W +: ELEM_W] : '0;
    end
    beat.element_valid = lane_en;
    beat.inter_end     = inter_end;
    beat.accum_end     = accum_end;
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    beat_d  = beat_q;
    inter_d = inter_q;
    accum_d = accum_q;
    done_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          cfg_d   = cfg_sanitize(i_cfg_lane_cnt, i_cfg_inter_len, i_cfg_accum_len,
                                 i_cfg_job_len);
          beat_d  = '0;
          inter_d = '0;
          accum_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (in_acc) begin
          push = 1'b1;
          // Nested wrap: beat -> inter group -> accumulation; the job ends on the last one.
          if (inter_end) begin
            beat_d = '0;
            if (accum_end) begin
              inter_d = '0;
              if (job_last) begin
                state_d = StDrain;
              end else begin
                accum_d = accum_q + CntOne;
              end
            end else begin
              inter_d = inter_q + CntOne;
            end
          end else begin
            beat_d = beat_q + CntOne;
          end
        end
      end
      StDrain: begin
        if (entries == 2'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cfg_q   <= '0;
      beat_q  <= '0;
      inter_q <= '0;
      accum_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      beat_q  <= beat_d;
      inter_q <= inter_d;
      accum_q <= accum_d;
      done_q  <= done_d;
    end
  end

  tx_skid_buf #(
    .T(mac_ifm_port)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_push   (push),
    .i_data   (beat),
    .o_valid  (o_valid),
    .o_data   (o_ifm),
    .i_ready  (i_ready),
    .o_entries(entries)
  );

`ifdef MAC_IFM_FEEDER_STAT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && i_start) begin
      stall_d = '0;
    end else if (o_valid && !i_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_ifm_feeder.sv
// Directed self-checking bench for mac_ifm_feeder; expected beats come from a small
// index-based model of the lane mask and loop flags.
module tb_mac_ifm_feeder;

  import mac_pkg::*;
  import tx_pkg::*;

  localparam int unsigned EW = MAC_W_ELEMENT;
  localparam int unsigned DW = EW * MAC_LANES;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [6:0]    i_cfg_lane_cnt = '0;
  logic [15:0]   i_cfg_inter_len = '0;
  logic [15:0]   i_cfg_accum_len = '0;
  logic [15:0]   i_cfg_job_len = '0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_ready, o_valid, o_busy, o_done;
  mac_ifm_port   o_ifm;
`ifdef MAC_IFM_FEEDER_STAT_EN
  logic [31:0]   o_stall_cnt;
`endif

  mac_ifm_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_cfg_lane_cnt (i_cfg_lane_cnt),
    .i_cfg_inter_len(i_cfg_inter_len),
    .i_cfg_accum_len(i_cfg_accum_len),
    .i_cfg_job_len  (i_cfg_job_len),
    .i_data         (i_data),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_ifm          (o_ifm),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_busy         (o_busy),
    .o_done         (o_done)
`ifdef MAC_IFM_FEEDER_STAT_EN
    ,
    .o_stall_cnt    (o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  mac_ifm_port out_q[$];
  int cyc = 0, last_pop = 0, done_at = 0, done_cnt = 0;

  // Edge-sampled monitor: a value seen at edge k was driven by edge k-1.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (o_valid && i_ready) begin
      out_q.push_back(o_ifm);
      last_pop = cyc;
    end
    if (o_done) begin
      done_cnt = done_cnt + 1;
      done_at  = cyc;
    end
  end

  function automatic logic [DW-1:0] gen(input int idx);
    logic [DW-1:0] v;
    for (int i = 0; i < int'(MAC_LANES); i++) v[i*EW +: EW] = EW'(idx * 17 + i * 3 + 1);
    return v;
  endfunction

  function automatic mac_ifm_port exp_beat(input int idx, input int lane, input int inter,
                                           input int accum, input logic [DW-1:0] din);
    mac_ifm_port e;
    e = '0;
    for (int i = 0; i < int'(MAC_LANES); i++) begin
      if (i < lane) begin
        e.element_valid[i] = 1'b1;
        e.data[i]          = din[i*EW +: EW];
      end
    end
    e.inter_end = ((idx % inter) == inter - 1);
    e.accum_end = e.inter_end && (((idx / inter) % accum) == accum - 1);
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int lane, input int inter, input int accum, input int job);
    i_cfg_lane_cnt  = 7'(lane);
    i_cfg_inter_len = 16'(inter);
    i_cfg_accum_len = 16'(accum);
    i_cfg_job_len   = 16'(job);
    i_start         = 1'b1;
    cycle();
    i_start         = 1'b0;
    // Junk cfg outside the start cycle must have no effect.
    i_cfg_lane_cnt  = 7'd1;
    i_cfg_inter_len = 16'd9;
    i_cfg_accum_len = 16'd9;
    i_cfg_job_len   = 16'd9;
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    int n;
    i_valid = 1'b1;
    i_data  = d;
    n = 0;
    while (!o_ready && n < 100) begin
      cycle();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout o_ready=%0b required 1", o_ready);
    end
    cycle();
    i_valid = 1'b0;
  endtask

  task automatic send(input int idx);
    send_data(gen(idx));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout o_busy=%0b required 0", o_busy);
    end
    cycle();
    cycle();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    cycle();
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_o_ready got %b required 0", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b required 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_o_busy got %b required 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_o_done got %b required 0", o_done); end
    checks++; if (o_ifm !== '0) begin errors++; $display("FAIL reset_o_ifm got %h required 0", o_ifm); end
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    int d0, c0;
    mac_ifm_port e;
    out_q.delete();
    d0 = done_cnt;
    i_ready = 1'b1;
    start_job(64, 3, 2, 1);
    c0 = cyc;
    send(0);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL basic_latency o_valid got %b required 1", o_valid); end
    for (int k = 1; k < 6; k++) send(k);
    checks++; if (cyc - c0 != 6) begin errors++; $display("FAIL basic_throughput cycles got %0d required 6", cyc - c0); end
    wait_idle();
    checks++; if (out_q.size() != 6) begin errors++; $display("FAIL basic_count got %0d required 6", out_q.size()); end
    for (int k = 0; k < 6 && k < out_q.size(); k++) begin
      e = exp_beat(k, 64, 3, 2, gen(k));
      checks++;
      if (out_q[k] !== e) begin
        errors++;
        $display("FAIL basic_beat%0d got ie=%b ae=%b data=%h required ie=%b ae=%b data=%h",
                 k, out_q[k].inter_end, out_q[k].accum_end, out_q[k].data,
                 e.inter_end, e.accum_end, e.data);
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count got %0d required 1", done_cnt - d0); end
    checks++; if (done_at != last_pop + 2) begin errors++; $display("FAIL basic_done_timing got %0d required %0d", done_at, last_pop + 2); end
  endtask

  task automatic test_lane_mask();
    logic [DW-1:0] ed;
    out_q.delete();
    ed = '0;
    ed[5*EW-1:0] = '1;
    i_ready = 1'b1;
    start_job(5, 1, 1, 1);
    send_data('1);
    wait_idle();
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL mask_count got %0d required 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++; if (out_q[0].element_valid !== 64'h1F) begin errors++; $display("FAIL mask_ev got %h required 1f", out_q[0].element_valid); end
      checks++; if (out_q[0].data !== ed) begin errors++; $display("FAIL mask_data got %h required %h", out_q[0].data, ed); end
      checks++; if ({out_q[0].inter_end, out_q[0].accum_end} !== 2'b11) begin errors++; $display("FAIL mask_flags got %b%b required 11", out_q[0].inter_end, out_q[0].accum_end); end
    end
  endtask

  task automatic test_stall();
    mac_ifm_port head, e;
    out_q.delete();
    i_ready = 1'b0;
    start_job(64, 4, 2, 1);
    i_valid = 1'b1;
    i_data  = gen(0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_pre_valid got %b required 0", o_valid); end
    cycle();
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_first_valid got %b required 1", o_valid); end
    head   = o_ifm;
    i_data = gen(1);
    cycle();
    i_data = gen(2);
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b required 0", k, o_ready); end
      checks++; if (o_ifm !== head) begin errors++; $display("FAIL stall_hold%0d got %h required %h", k, o_ifm, head); end
      if (k < 3) cycle();
    end
    i_ready = 1'b1;
    e = exp_beat(0, 64, 4, 2, gen(0));
    checks++; if (head !== e) begin errors++; $display("FAIL stall_head got %h required %h", head, e); end
    for (int k = 2; k < 8; k++) send(k);
    wait_idle();
    checks++; if (out_q.size() != 8) begin errors++; $display("FAIL stall_count got %0d required 8", out_q.size()); end
    for (int k = 0; k < 8 && k < out_q.size(); k++) begin
      e = exp_beat(k, 64, 4, 2, gen(k));
      checks++;
      if (out_q[k] !== e) begin
        errors++;
        $display("FAIL stall_beat%0d got ie=%b ae=%b data=%h required ie=%b ae=%b data=%h",
                 k, out_q[k].inter_end, out_q[k].accum_end, out_q[k].data,
                 e.inter_end, e.accum_end, e.data);
      end
    end
`ifdef MAC_IFM_FEEDER_STAT_EN
    checks++; if (o_stall_cnt !== 32'd4) begin errors++; $display("FAIL stall_cnt got %0d required 4", o_stall_cnt); end
`endif
  endtask

  task automatic test_zero_cfg();
    int d0;
    mac_ifm_port e;
    out_q.delete();
    d0 = done_cnt;
    i_ready = 1'b1;
    start_job(0, 0, 0, 0);
    send(0);
    wait_idle();
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL zero_count got %0d required 1", out_q.size()); end
    e = exp_beat(0, 64, 1, 1, gen(0));
    if (out_q.size() > 0) begin
      checks++; if (out_q[0] !== e) begin errors++; $display("FAIL zero_beat got ev=%h ie=%b ae=%b required ev=%h ie=%b ae=%b", out_q[0].element_valid, out_q[0].inter_end, out_q[0].accum_end, e.element_valid, e.inter_end, e.accum_end); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_reset_midjob();
    int d0;
    mac_ifm_port e;
    out_q.delete();
    d0 = done_cnt;
    i_ready = 1'b0;
    start_job(64, 8, 1, 1);
    send(0);
    send(1);
    checks++; if ({o_valid, o_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_full got valid=%b ready=%b required valid=1 ready=0", o_valid, o_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b required 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b required 0", o_busy); end
    cycle();
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done got %0d required %0d", done_cnt, d0); end
    i_ready = 1'b1;
    start_job(64, 2, 1, 1);
    send(10);
    send(11);
    wait_idle();
    checks++; if (out_q.size() != 2) begin errors++; $display("FAIL rstmid_rerun_count got %0d required 2", out_q.size()); end
    for (int k = 0; k < 2 && k < out_q.size(); k++) begin
      e = exp_beat(k, 64, 2, 1, gen(10 + k));
      checks++; if (out_q[k] !== e) begin errors++; $display("FAIL rstmid_rerun_beat%0d got ie=%b ae=%b required ie=%b ae=%b", k, out_q[k].inter_end, out_q[k].accum_end, e.inter_end, e.accum_end); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rstmid_rerun_done got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_start_ignored();
    int d0;
    mac_ifm_port e;
    out_q.delete();
    d0 = done_cnt;
    i_ready = 1'b1;
    start_job(64, 2, 2, 1);
    send(0);
    i_start         = 1'b1;
    i_cfg_lane_cnt  = 7'd3;
    i_cfg_inter_len = 16'd1;
    i_cfg_accum_len = 16'd1;
    i_cfg_job_len   = 16'd1;
    send(1);
    i_start = 1'b0;
    send(2);
    send(3);
    wait_idle();
    checks++; if (out_q.size() != 4) begin errors++; $display("FAIL restart_count got %0d required 4", out_q.size()); end
    for (int k = 0; k < 4 && k < out_q.size(); k++) begin
      e = exp_beat(k, 64, 2, 2, gen(k));
      checks++; if (out_q[k] !== e) begin errors++; $display("FAIL restart_beat%0d got ev=%h ie=%b ae=%b required ev=%h ie=%b ae=%b", k, out_q[k].element_valid, out_q[k].inter_end, out_q[k].accum_end, e.element_valid, e.inter_end, e.accum_end); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL restart_done got %0d required 1", done_cnt - d0); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_lane_mask();
    test_stall();
    test_zero_cfg();
    test_reset_midjob();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
